maindec_exc_seq: RTL and testbench
==================================

Name: maindec_exc_seq

Overview:
- Registered, exception-aware successor of the single-cycle main decoder for the LEGv8 core.
- Decodes the 11-bit opcode field into datapath control and adds an exception sequencer.
- The sequencer detects invalid opcodes and prioritised external interrupts, flushes the pipeline for a set number of cycles, runs the handler, and returns on ERET.
- Sits between the IF/ID register and the ID/EX control fields.

Parameters:
- NUM_IRQ, 2, number of external interrupt lines (1..8).
- FLUSH_CYCLES, 2, cycles with Flush asserted after an exception is taken (1..15).
- ESTATUS_W, 4, width of EStatus (≥4).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  11  instruction bits [31:21].
- OpValid  in  1  Op holds a real instruction this cycle.
- ExtIRQ  in  NUM_IRQ  level interrupt requests; bit 0 has highest priority.
- Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ERet  out  1  registered control.
- ALUSrc  out  2  registered control.
- ALUOp  out  2  registered control.
- EStatus  out  ESTATUS_W  cause of the last exception; sticky.
- ExcTaken  out  1  one-cycle pulse when an exception is accepted.
- Flush  out  1  squashes the younger pipeline stages.
- InHandler  out  1  high while the exception handler runs.
- CtrlValid  out  1  control outputs are meaningful.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, EStatus=0, state RUN, flush counter 0.
- Decode is combinational. Every control output and CtrlValid is registered, giving 1-cycle latency from Op/OpValid.
- Decode table. Any value not listed is 0.
  - LDUR 11111000010: ALUSrc=01, MemtoReg, RegWrite, MemRead.
  - STUR 11111000000: Reg2Loc, ALUSrc=01, MemWrite.
  - CBZ 10110100xxx: Reg2Loc, Branch, ALUOp=01.
  - ADD 10001011000 / SUB 11001011000 / AND 10001010000 / ORR 10101010000: RegWrite, ALUOp=10.
  - ERET 11010110100: Branch, ALUOp=01, ERet. MemtoReg is driven 0.
  - MRS 1101010100x: Reg2Loc, ALUSrc=10, RegWrite, ALUOp=01.
- Invalid instruction: OpValid=1 and Op matches no row, or ERET decoded while in state RUN.
- State RUN:
  - Invalid instruction → EStatus=0010, go to FLUSH.
  - Otherwise, any ExtIRQ bit set → EStatus = 8 + index of the lowest set bit, go to FLUSH.
  - Invalid has priority over IRQ when both occur in the same cycle.
- State FLUSH:
  - Entry cycle (registered): ExcTaken=1 for exactly one cycle.
  - Flush=1 for exactly FLUSH_CYCLES cycles.
  - All control outputs forced 0, CtrlValid=0.
  - Op and ExtIRQ are ignored.
  - Then go to HANDLER.
- State HANDLER:
  - InHandler=1; decode proceeds normally; ExtIRQ is masked.
  - Valid ERET → ERet=1 on the registered output, then RUN on the next cycle. InHandler drops in the same cycle ERet is presented.
  - Invalid instruction in HANDLER (double fault) → EStatus=0011, re-enter FLUSH.
- EStatus changes only when an exception is accepted. It holds across ERET until the next exception.
- OpValid=0: control outputs 0, CtrlValid=0, no invalid detection. IRQs are still accepted in RUN.
- An IRQ asserted and dropped while in FLUSH or HANDLER is lost (level-sensitive, no latching).
- Reset asserted mid-FLUSH or mid-HANDLER returns immediately to the reset state.

Test Plan:
- Release reset, OpValid=1, Op=11111000010 → next cycle: MemRead=1, MemtoReg=1, RegWrite=1, ALUSrc=01, CtrlValid=1, ExcTaken=0.
- Op=00000000000, OpValid=1 in RUN:
  - Next edge: ExcTaken=1 for 1 cycle, EStatus=0010.
  - Flush=1 for 2 cycles with CtrlValid=0, then InHandler=1.
- ExtIRQ=2'b11 together with Op=ADD in RUN → EStatus=1000, FLUSH entered, no RegWrite pulse for the ADD.
- In HANDLER, ExtIRQ=2'b10 held for 5 cycles → no exception. Then Op=11010110100 → ERet=1, Branch=1, ALUOp=01; RUN afterwards with EStatus still 1000.
- Op=ERET in RUN → EStatus=0010, FLUSH. In HANDLER, an invalid Op → EStatus=0011, FLUSH re-entered.
- Reset pulsed low during the 2nd Flush cycle → all outputs 0 asynchronously. After release, Op=MRS 11010101001 → ALUSrc=10, Reg2Loc=1, RegWrite=1.

Source files
------------

// File: rtl/maindec_exc_seq.sv
// Registered LEGv8 main decoder with an exception sequencer that detects invalid
// opcodes and prioritised external interrupts, flushes, runs the handler and returns on ERET.
module maindec_exc_seq #(
  parameter int NUM_IRQ      = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int ESTATUS_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          Op,
  input  logic                 OpValid,
  input  logic [NUM_IRQ-1:0]   ExtIRQ,
  output logic                 Reg2Loc,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 Branch,
  output logic                 ERet,
  output logic [1:0]           ALUSrc,
  output logic [1:0]           ALUOp,
  output logic [ESTATUS_W-1:0] EStatus,
  output logic                 ExcTaken,
  output logic                 Flush,
  output logic                 InHandler,
  output logic                 CtrlValid
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HANDLER} state_t;

  state_t               r_state;
  logic [3:0]           r_flushCnt;
  logic [10:0]          r_ctrl;
  logic [ESTATUS_W-1:0] r_estatus;
  logic                 r_excTaken;
  logic                 r_flush;
  logic                 r_inHandler;
  logic                 r_ctrlValid;

  logic [10:0] w_ctrl;
  logic        w_known;
  logic        w_isEret;
  logic        w_invalid;
  logic        w_irqAny;
  logic [2:0]  w_irqIdx;
  logic        w_takeExc;

  // Control bundle: {Reg2Loc, ALUSrc[1:0], MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0], ERet}
  always_comb begin
    w_ctrl   = '0;
    w_known  = 1'b1;
    w_isEret = 1'b0;
    casez (Op)
      11'b11111000010: w_ctrl = {1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
      11'b11111000000: w_ctrl = {1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
      11'b10110100???: w_ctrl = {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0};
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: w_ctrl = {1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};
      11'b11010110100: begin
        w_ctrl   = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1};
        w_isEret = 1'b1;
      end
      11'b1101010100?: w_ctrl = {1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
      default:         w_known = 1'b0;
    endcase
  end

  // Scan from the top so the lowest set bit (highest priority) wins.
  always_comb begin
    w_irqIdx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (ExtIRQ[i]) w_irqIdx = 3'(i);
    end
  end

  assign w_irqAny  = |ExtIRQ;
  assign w_invalid = OpValid && (!w_known || (w_isEret && (r_state == ST_RUN)));
  assign w_takeExc = w_invalid || ((r_state == ST_RUN) && w_irqAny);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_flushCnt  <= '0;
      r_ctrl      <= '0;
      r_estatus   <= '0;
      r_excTaken  <= 1'b0;
      r_flush     <= 1'b0;
      r_inHandler <= 1'b0;
      r_ctrlValid <= 1'b0;
    end else begin
      r_excTaken <= 1'b0;
      case (r_state)
        ST_RUN, ST_HANDLER: begin
          if (w_takeExc) begin
            if (w_invalid)
              r_estatus <= (r_state == ST_RUN) ? ESTATUS_W'(2) : ESTATUS_W'(3);
            else
              r_estatus <= ESTATUS_W'(4'd8 + {1'b0, w_irqIdx});
            r_state     <= ST_FLUSH;
            r_flushCnt  <= 4'(FLUSH_CYCLES - 1);
            r_excTaken  <= 1'b1;
            r_flush     <= 1'b1;
            r_inHandler <= 1'b0;
            r_ctrl      <= '0;
            r_ctrlValid <= 1'b0;
          end else begin
            r_ctrl      <= OpValid ? w_ctrl : '0;
            r_ctrlValid <= OpValid;
            if ((r_state == ST_HANDLER) && OpValid && w_isEret) begin
              r_state     <= ST_RUN;
              r_inHandler <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          r_ctrl      <= '0;
          r_ctrlValid <= 1'b0;
          if (r_flushCnt == 4'd0) begin
            r_flush     <= 1'b0;
            r_inHandler <= 1'b1;
            r_state     <= ST_HANDLER;
          end else begin
            r_flushCnt <= r_flushCnt - 4'd1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, ERet} = r_ctrl;
  assign EStatus   = r_estatus;
  assign ExcTaken  = r_excTaken;
  assign Flush     = r_flush;
  assign InHandler = r_inHandler;
  assign CtrlValid = r_ctrlValid;

endmodule

// File: tb/tb_maindec_exc_seq.sv
// Scoreboard bench for maindec_exc_seq: the driver pushes model predictions,
// an independent monitor pops and compares them after every clock edge or async reset.
module tb_maindec_exc_seq;
  localparam int NUM_IRQ      = 2;
  localparam int FLUSH_CYCLES = 2;
  localparam int ESTATUS_W    = 4;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ERET = 11'b11010110100;
  localparam logic [10:0] OP_MRS  = 11'b11010101000;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [10:0]          Op;
  logic                 OpValid;
  logic [NUM_IRQ-1:0]   ExtIRQ;
  logic                 Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ERet;
  logic [1:0]           ALUSrc, ALUOp;
  logic [ESTATUS_W-1:0] EStatus;
  logic                 ExcTaken, Flush, InHandler, CtrlValid;

  maindec_exc_seq #(.NUM_IRQ(NUM_IRQ), .FLUSH_CYCLES(FLUSH_CYCLES), .ESTATUS_W(ESTATUS_W)) dut (
    .clk(clk), .reset(reset), .Op(Op), .OpValid(OpValid), .ExtIRQ(ExtIRQ),
    .Reg2Loc(Reg2Loc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .ERet(ERet), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .EStatus(EStatus), .ExcTaken(ExcTaken), .Flush(Flush), .InHandler(InHandler),
    .CtrlValid(CtrlValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] val;
    string       tag;
  } exp_t;

  exp_t scoreQ[$];
  int   checks   = 0;
  int   failures = 0;
  logic rstDrive;

  // Reference model: 0 = running, 1 = flushing, 2 = in handler
  int mMode;
  int mFlushShown;
  int mEst;

  logic [18:0] dutVec;
  assign dutVec = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, ERet,
                   EStatus, ExcTaken, Flush, InHandler, CtrlValid};

  // Returns {known, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, ERet}
  function automatic logic [11:0] modelDecode(input logic [10:0] op);
    logic       known, r2l, m2r, rw, mr, mw, br, er;
    logic [1:0] src, aop;
    {known, r2l, m2r, rw, mr, mw, br, er} = '0;
    src = 2'b00;
    aop = 2'b00;
    if (op == OP_LDUR) begin
      known = 1; src = 2'b01; m2r = 1; rw = 1; mr = 1;
    end else if (op == OP_STUR) begin
      known = 1; r2l = 1; src = 2'b01; mw = 1;
    end else if ((op & 11'h7F8) == OP_CBZ) begin
      known = 1; r2l = 1; br = 1; aop = 2'b01;
    end else if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
      known = 1; rw = 1; aop = 2'b10;
    end else if (op == OP_ERET) begin
      known = 1; br = 1; aop = 2'b01; er = 1;
    end else if ((op & 11'h7FE) == OP_MRS) begin
      known = 1; r2l = 1; src = 2'b10; rw = 1; aop = 2'b01;
    end
    return {known, r2l, src, m2r, rw, mr, mw, br, aop, er};
  endfunction

  function automatic int lowestIrq(input logic [NUM_IRQ-1:0] irq);
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [18:0] packOut(input logic [10:0] ctrl, input int est,
                                          input logic exc, input logic fl,
                                          input logic ih, input logic cv);
    return {ctrl, ESTATUS_W'(est), exc, fl, ih, cv};
  endfunction

  task automatic modelReset();
    mMode       = 0;
    mFlushShown = 0;
    mEst        = 0;
  endtask

  task automatic applyStimulus(input logic [10:0] op, input logic v,
                               input logic [NUM_IRQ-1:0] irq, input string tag);
    logic [11:0] d;
    logic        fault, irqTaken, leaving;
    exp_t        e;
    @(negedge clk);
    reset   = rstDrive;
    Op      = op;
    OpValid = v;
    ExtIRQ  = irq;
    d       = modelDecode(op);
    e.tag   = tag;
    if (!reset) begin
      modelReset();
      e.val = '0;
    end else if (mMode == 1) begin
      if (mFlushShown < FLUSH_CYCLES) begin
        mFlushShown++;
        e.val = packOut('0, mEst, 1'b0, 1'b1, 1'b0, 1'b0);
      end else begin
        mMode = 2;
        e.val = packOut('0, mEst, 1'b0, 1'b0, 1'b1, 1'b0);
      end
    end else begin
      fault    = v && (!d[11] || (op == OP_ERET && mMode == 0));
      irqTaken = (mMode == 0) && (irq != 0);
      if (fault || irqTaken) begin
        mEst        = fault ? ((mMode == 0) ? 2 : 3) : 8 + lowestIrq(irq);
        mMode       = 1;
        mFlushShown = 1;
        e.val = packOut('0, mEst, 1'b1, 1'b1, 1'b0, 1'b0);
      end else begin
        leaving = (mMode == 2) && v && (op == OP_ERET);
        e.val = packOut(v ? d[10:0] : 11'b0, mEst, 1'b0, 1'b0, (mMode == 2) && !leaving, v);
        if (leaving) mMode = 0;
      end
    end
    scoreQ.push_back(e);
  endtask

  task automatic pulseResetAsync(input string tag);
    exp_t e;
    @(posedge clk);
    #3;
    e.val = '0;
    e.tag = tag;
    scoreQ.push_back(e);
    rstDrive = 1'b0;
    reset    = 1'b0;
    modelReset();
  endtask

  // Monitor: one pending prediction is consumed per clock edge or asynchronous reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge reset);
      #1;
      if (scoreQ.size() > 0) begin
        e = scoreQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic checkOutput(input exp_t e);
    checks++;
    if (dutVec !== e.val) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", e.tag, dutVec, e.val, $time);
    end
  endtask

  function automatic logic [10:0] randomOp();
    logic [10:0] op;
    case ($urandom_range(0, 9))
      0: op = OP_LDUR;
      1: op = OP_STUR;
      2: op = OP_CBZ | 11'($urandom_range(0, 7));
      3: case ($urandom_range(0, 3))
           0: op = OP_ADD;
           1: op = OP_SUB;
           2: op = OP_AND;
           default: op = OP_ORR;
         endcase
      4, 7: op = OP_ERET;
      5: op = OP_MRS | 11'($urandom_range(0, 1));
      6: op = 11'($urandom);
      8: op = OP_ADD;
      default: op = 11'h000;
    endcase
    return op;
  endfunction

  initial begin
    logic [10:0]        rOp;
    logic               rV;
    logic [NUM_IRQ-1:0] rIrq;
    reset    = 1'b0;
    rstDrive = 1'b0;
    Op       = '0;
    OpValid  = 1'b0;
    ExtIRQ   = '0;
    modelReset();
    applyStimulus(OP_LDUR, 1, 2'b00, "resetHold0");
    applyStimulus(OP_LDUR, 1, 2'b11, "resetHold1");
    rstDrive = 1'b1;

    applyStimulus(OP_LDUR, 1, 2'b00, "ldurDecode");
    applyStimulus(11'h000, 1, 2'b00, "invalidOpTaken");
    applyStimulus(OP_LDUR, 1, 2'b11, "flushCycle1");
    applyStimulus(OP_ADD, 1, 2'b00, "flushCycle2");
    applyStimulus(OP_ADD, 1, 2'b00, "handlerEntry");
    applyStimulus(OP_ADD, 1, 2'b00, "handlerAdd");
    applyStimulus(OP_ERET, 1, 2'b00, "eretReturn1");

    applyStimulus(OP_ADD, 1, 2'b11, "irqPriority");
    applyStimulus(OP_ADD, 1, 2'b00, "irqFlush1");
    applyStimulus(OP_ADD, 1, 2'b00, "irqFlush2");
    applyStimulus(OP_ADD, 0, 2'b00, "irqHandlerEntry");
    for (int i = 0; i < 5; i++) applyStimulus(OP_ADD, 0, 2'b10, "irqMaskedInHandler");
    applyStimulus(OP_ERET, 1, 2'b10, "eretReturn2");
    applyStimulus(OP_ADD, 1, 2'b00, "addAfterEret");

    applyStimulus(OP_ERET, 1, 2'b00, "eretInRun");
    applyStimulus(11'h000, 0, 2'b00, "eretFlush1");
    applyStimulus(11'h000, 0, 2'b00, "eretFlush2");
    applyStimulus(OP_STUR, 1, 2'b00, "eretHandlerEntry");
    applyStimulus(OP_CBZ | 11'd5, 1, 2'b00, "handlerCbz");
    applyStimulus(11'h7FF, 1, 2'b00, "doubleFault");
    applyStimulus(11'h000, 0, 2'b00, "dfFlush1");
    applyStimulus(11'h000, 0, 2'b00, "dfFlush2");
    applyStimulus(11'h000, 0, 2'b00, "dfHandlerEntry");
    applyStimulus(OP_ERET, 1, 2'b00, "eretReturn3");

    applyStimulus(11'h000, 0, 2'b10, "irqNoOpValid");
    applyStimulus(OP_ADD, 1, 2'b00, "preResetFlush2");
    pulseResetAsync("asyncResetMidFlush");
    applyStimulus(OP_ADD, 1, 2'b01, "resetHeld");
    rstDrive = 1'b1;
    applyStimulus(OP_MRS | 11'd1, 1, 2'b00, "mrsAfterReset");

    for (int i = 0; i < 400; i++) begin
      rOp  = randomOp();
      rV   = ($urandom_range(0, 7) != 0);
      rIrq = ($urandom_range(0, 7) == 0) ? NUM_IRQ'($urandom) : '0;
      applyStimulus(rOp, rV, rIrq, "random");
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (scoreQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboardDrain: got %0d pending expected 0", scoreQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
